// File: rtl/slot_pkg.sv
// Shared types and default parameter values for the slot machine controller.
package slot_pkg;

  // Game controller states.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SPIN     = 3'd1,
    STOPPING = 3'd2,
    EVAL     = 3'd3,
    WIN      = 3'd4,
    LOSE     = 3'd5
  } state_e;

  localparam int DEF_NUM_REELS    = 3;
  localparam int DEF_NUM_SYMBOLS  = 8;
  localparam int DEF_SYM_W        = 3;
  localparam int DEF_SPIN_CYCLES  = 1 << 26;
  localparam int DEF_STOP_GAP     = 1 << 24;
  localparam int DEF_CREDIT_W     = 8;
  localparam int DEF_INIT_CREDITS = 10;
  localparam int DEF_PAYOUT       = 5;

endpackage

// File: rtl/slot_reel.sv
// One reel: a mod-NUM_SYMBOLS symbol counter that advances while the game is
// spinning and freezes once told to stop. The stopping edge still advances.
module slot_reel
  import slot_pkg::*;
#(
  parameter int NUM_SYMBOLS = DEF_NUM_SYMBOLS,
  parameter int SYM_W       = DEF_SYM_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_stop,
  input  logic             advance,
  input  logic             stop,
  output logic [SYM_W-1:0] sym,
  output logic             stopped
);

  localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(NUM_SYMBOLS - 1);

  logic [SYM_W-1:0] sym_q, sym_d;
  logic             stopped_q, stopped_d;

  // Next symbol / stop flag: a new spin releases the reel, otherwise an
  // unstopped reel steps and may latch its stop on the same edge.
  always_comb begin
    sym_d     = sym_q;
    stopped_d = stopped_q;
    if (clear_stop) begin
      stopped_d = 1'b0;
    end else if (advance && !stopped_q) begin
      sym_d = (sym_q == SYM_LAST) ? '0 : sym_q + SYM_W'(1);
      if (stop) begin
        stopped_d = 1'b1;
      end
    end
  end

  // Reel registers; symbols survive idle periods and only reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      sym_q     <= '0;
      stopped_q <= 1'b0;
    end else begin
      sym_q     <= sym_d;
      stopped_q <= stopped_d;
    end
  end

  assign sym     = sym_q;
  assign stopped = stopped_q;

endmodule

// File: rtl/slot_game_ctrl.sv
// Slot machine game controller: takes a credit per spin, stops the reels one
// after another on fixed timing, then pays out when all reels show the same
// symbol. Results are held until acknowledged with clear.
module slot_game_ctrl
  import slot_pkg::*;
#(
  parameter int NUM_REELS    = DEF_NUM_REELS,
  parameter int NUM_SYMBOLS  = DEF_NUM_SYMBOLS,
  parameter int SYM_W        = DEF_SYM_W,
  parameter int SPIN_CYCLES  = DEF_SPIN_CYCLES,
  parameter int STOP_GAP     = DEF_STOP_GAP,
  parameter int CREDIT_W     = DEF_CREDIT_W,
  parameter int INIT_CREDITS = DEF_INIT_CREDITS,
  parameter int PAYOUT       = DEF_PAYOUT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       clear,
  output logic [NUM_REELS*SYM_W-1:0] reel_sym,
  output logic [NUM_REELS-1:0]       reel_stopped,
  output logic                       win,
  output logic                       lose,
  output logic                       busy,
  output logic [CREDIT_W-1:0]        credits,
  output logic                       no_credit
);

  // A terminal count of 1 still needs a 1-bit counter.
  localparam int SPIN_CW = (SPIN_CYCLES > 1) ? $clog2(SPIN_CYCLES) : 1;
  localparam int GAP_CW  = (STOP_GAP > 1) ? $clog2(STOP_GAP) : 1;
  localparam int IDX_W   = $clog2(NUM_REELS);

  localparam logic [SPIN_CW-1:0]  SPIN_LAST  = SPIN_CW'(SPIN_CYCLES - 1);
  localparam logic [GAP_CW-1:0]   GAP_LAST   = GAP_CW'(STOP_GAP - 1);
  localparam logic [IDX_W-1:0]    LAST_REEL  = IDX_W'(NUM_REELS - 1);
  localparam logic [CREDIT_W-1:0] CREDIT_MAX = '1;
  localparam logic [CREDIT_W-1:0] CREDIT_INI = CREDIT_W'(INIT_CREDITS);

  // Credit payout that clamps at the largest representable balance.
  function automatic logic [CREDIT_W-1:0] sat_add(input logic [CREDIT_W-1:0] a);
    logic [32:0] sum;
    sum = 33'(a) + 33'(PAYOUT);
    if (sum > 33'(CREDIT_MAX)) begin
      return CREDIT_MAX;
    end
    return sum[CREDIT_W-1:0];
  endfunction

  state_e               state_q, state_d;
  logic [CREDIT_W-1:0]  credits_q, credits_d;
  logic [SPIN_CW-1:0]   spin_cnt_q, spin_cnt_d;
  logic [GAP_CW-1:0]    gap_cnt_q, gap_cnt_d;
  logic [IDX_W-1:0]     reel_idx_q, reel_idx_d;
  logic                 win_q, win_d;
  logic                 lose_q, lose_d;
  logic                 busy_q, busy_d;

  logic                 clear_stop;
  logic                 advance;
  logic [NUM_REELS-1:0] stop_vec;
  logic                 all_equal;

  logic [SYM_W-1:0]     sym_w [NUM_REELS];
  logic [NUM_REELS-1:0] stopped_w;

  for (genvar g = 0; g < NUM_REELS; g++) begin : g_reel
    slot_reel #(
      .NUM_SYMBOLS (NUM_SYMBOLS),
      .SYM_W       (SYM_W)
    ) u_reel (
      .clk        (clk),
      .reset      (reset),
      .clear_stop (clear_stop),
      .advance    (advance),
      .stop       (stop_vec[g]),
      .sym        (sym_w[g]),
      .stopped    (stopped_w[g])
    );
  end

  // Pack per-reel symbols onto the output bus and detect a full match.
  always_comb begin
    reel_sym  = '0;
    all_equal = 1'b1;
    for (int i = 0; i < NUM_REELS; i++) begin
      reel_sym[i*SYM_W +: SYM_W] = sym_w[i];
      if (sym_w[i] != sym_w[0]) begin
        all_equal = 1'b0;
      end
    end
  end

  // Next-state, counters, credits and reel controls.
  always_comb begin
    state_d    = state_q;
    credits_d  = credits_q;
    spin_cnt_d = spin_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    reel_idx_d = reel_idx_q;
    clear_stop = 1'b0;
    advance    = 1'b0;
    stop_vec   = '0;

    case (state_q)
      IDLE: begin
        if (start && (credits_q != '0)) begin
          state_d    = SPIN;
          credits_d  = credits_q - CREDIT_W'(1);
          clear_stop = 1'b1;
          spin_cnt_d = '0;
        end
      end
      SPIN: begin
        advance = 1'b1;
        if (spin_cnt_q == SPIN_LAST) begin
          stop_vec[0] = 1'b1;
          state_d     = STOPPING;
          spin_cnt_d  = '0;
          gap_cnt_d   = '0;
          reel_idx_d  = IDX_W'(1);
        end else begin
          spin_cnt_d = spin_cnt_q + SPIN_CW'(1);
        end
      end
      STOPPING: begin
        advance = 1'b1;
        if (gap_cnt_q == GAP_LAST) begin
          stop_vec[reel_idx_q] = 1'b1;
          gap_cnt_d            = '0;
          if (reel_idx_q == LAST_REEL) begin
            state_d    = EVAL;
            reel_idx_d = '0;
          end else begin
            reel_idx_d = reel_idx_q + IDX_W'(1);
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_CW'(1);
        end
      end
      EVAL: begin
        if (all_equal) begin
          state_d   = WIN;
          credits_d = sat_add(credits_q);
        end else begin
          state_d = LOSE;
        end
      end
      WIN, LOSE: begin
        if (clear) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    win_d  = (state_d == WIN);
    lose_d = (state_d == LOSE);
    busy_d = (state_d == SPIN) || (state_d == STOPPING) || (state_d == EVAL);
  end

  // Controller registers; reset returns to a fresh game with full credits.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      credits_q  <= CREDIT_INI;
      spin_cnt_q <= '0;
      gap_cnt_q  <= '0;
      reel_idx_q <= '0;
      win_q      <= 1'b0;
      lose_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      credits_q  <= credits_d;
      spin_cnt_q <= spin_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      reel_idx_q <= reel_idx_d;
      win_q      <= win_d;
      lose_q     <= lose_d;
      busy_q     <= busy_d;
    end
  end

  assign reel_stopped = stopped_w;
  assign win          = win_q;
  assign lose         = lose_q;
  assign busy         = busy_q;
  assign credits      = credits_q;
  assign no_credit    = (credits_q == '0);

endmodule

// File: tb/tb_slot_game_ctrl.sv
// Bench for slot_game_ctrl: four instances with different stop gaps and
// starting credits share one stimulus stream; a timeline model predicts each.
module tb_slot_game_ctrl;

  localparam int NR  = 3;
  localparam int NS  = 8;
  localparam int SW  = 3;
  localparam int SC  = 4;
  localparam int CW  = 4;
  localparam int PAY = 5;
  localparam int NI  = 4;

  logic clk = 1'b0;
  logic reset, start, clear;

  logic [NR*SW-1:0] o_sym  [NI];
  logic [NR-1:0]    o_stp  [NI];
  logic [CW-1:0]    o_cred [NI];
  logic             o_win  [NI];
  logic             o_lose [NI];
  logic             o_busy [NI];
  logic             o_nc   [NI];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    slot_game_ctrl #(
      .NUM_REELS    (NR),
      .NUM_SYMBOLS  (NS),
      .SYM_W        (SW),
      .SPIN_CYCLES  (SC),
      .STOP_GAP     ((g == 1) ? 2 : (g == 3) ? 1 : 8),
      .CREDIT_W     (CW),
      .INIT_CREDITS ((g == 2) ? 14 : 10),
      .PAYOUT       (PAY)
    ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .clear        (clear),
      .reel_sym     (o_sym[g]),
      .reel_stopped (o_stp[g]),
      .win          (o_win[g]),
      .lose         (o_lose[g]),
      .busy         (o_busy[g]),
      .credits      (o_cred[g]),
      .no_credit    (o_nc[g])
    );
  end

  // Timeline model: mode 0 idle, 1 running, 2 won, 3 lost. t counts edges
  // since the accepted start; reel k stops at edge SC + k*gap.
  int m_mode [NI];
  int m_t    [NI];
  int m_cred [NI];
  int m_base [NI][NR];
  int m_sym  [NI][NR];
  bit m_stp  [NI][NR];

  function automatic int gap_of(int i);
    return (i == 1) ? 2 : (i == 3) ? 1 : 8;
  endfunction

  function automatic int init_of(int i);
    return (i == 2) ? 14 : 10;
  endfunction

  task automatic model_edge();
    for (int i = 0; i < NI; i++) begin
      if (reset) begin
        m_mode[i] = 0;
        m_cred[i] = init_of(i);
        for (int k = 0; k < NR; k++) begin
          m_sym[i][k] = 0;
          m_stp[i][k] = 0;
        end
      end else begin
        case (m_mode[i])
          0: if (start && m_cred[i] != 0) begin
            m_cred[i] = m_cred[i] - 1;
            m_mode[i] = 1;
            m_t[i]    = 0;
            for (int k = 0; k < NR; k++) begin
              m_base[i][k] = m_sym[i][k];
              m_stp[i][k]  = 0;
            end
          end
          1: begin
            int last;
            bit eq;
            m_t[i] = m_t[i] + 1;
            for (int k = 0; k < NR; k++) begin
              int st;
              st = SC + k * gap_of(i);
              m_sym[i][k] = (m_base[i][k] + ((m_t[i] < st) ? m_t[i] : st)) % NS;
              m_stp[i][k] = (m_t[i] >= st);
            end
            last = SC + (NR - 1) * gap_of(i);
            if (m_t[i] == last + 1) begin
              eq = 1;
              for (int k = 1; k < NR; k++) if (m_sym[i][k] != m_sym[i][0]) eq = 0;
              if (eq) begin
                m_mode[i] = 2;
                m_cred[i] = (m_cred[i] + PAY > 15) ? 15 : m_cred[i] + PAY;
              end else begin
                m_mode[i] = 3;
              end
            end
          end
          default: if (clear) m_mode[i] = 0;
        endcase
      end
    end
  endtask

  function automatic logic [19:0] exp_word(int i);
    logic [NR*SW-1:0] s;
    logic [NR-1:0]    p;
    s = '0;
    p = '0;
    for (int k = 0; k < NR; k++) begin
      s[k*SW +: SW] = SW'(m_sym[i][k]);
      p[k]          = m_stp[i][k];
    end
    return {s, p, CW'(m_cred[i]), m_cred[i] == 0, m_mode[i] == 1, m_mode[i] == 2, m_mode[i] == 3};
  endfunction

  function automatic logic [19:0] obs_word(int i);
    return {o_sym[i], o_stp[i], o_cred[i], o_nc[i], o_busy[i], o_win[i], o_lose[i]};
  endfunction

  function automatic bit any_running();
    for (int i = 0; i < NI; i++) if (m_mode[i] == 1) return 1;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset = 1; start = 1; clear = 1;
    tick();
    tick();
    reset = 0; start = 0; clear = 0;
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (obs_word(i) !== exp_word(i)) begin
        errors++;
        $display("FAIL reset_state inst%0d: got %h expected %h", i, obs_word(i), exp_word(i));
      end
      checks++;
      if (o_cred[i] !== CW'(init_of(i)) || o_sym[i] !== '0 || o_stp[i] !== '0 || o_busy[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_values inst%0d: cred %0d sym %h stp %b busy %b, expected cred %0d zeros",
                 i, o_cred[i], o_sym[i], o_stp[i], o_busy[i], init_of(i));
      end
    end
  endtask

  task automatic test_spec_games();
    start = 1;
    tick();
    start = 0;
    checks++;
    if (o_cred[0] !== 4'd9 || o_busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL start_debit: cred %0d busy %b, expected 9 1", o_cred[0], o_busy[0]);
    end
    for (int e = 1; e <= 21; e++) begin
      tick();
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (obs_word(i) !== exp_word(i)) begin
          errors++;
          $display("FAIL spec_games inst%0d edge%0d: got %h expected %h", i, e, obs_word(i), exp_word(i));
        end
      end
      if (e == 4) begin
        checks++;
        if (o_stp[0] !== 3'b001 || o_sym[0][2:0] !== 3'd4) begin
          errors++;
          $display("FAIL reel0_stop E4: stp %b sym %0d, expected 001 4", o_stp[0], o_sym[0][2:0]);
        end
      end
      if (e == 9) begin
        checks++;
        if (o_lose[1] !== 1'b1 || o_cred[1] !== 4'd9 || o_sym[1] !== {3'd0, 3'd6, 3'd4}) begin
          errors++;
          $display("FAIL lose_gap2 E9: lose %b cred %0d sym %h, expected 1 9 %h",
                   o_lose[1], o_cred[1], o_sym[1], {3'd0, 3'd6, 3'd4});
        end
      end
      if (e == 12) begin
        checks++;
        if (o_stp[0] !== 3'b011) begin
          errors++;
          $display("FAIL reel1_stop E12: stp %b, expected 011", o_stp[0]);
        end
      end
      if (e == 20) begin
        checks++;
        if (o_stp[0] !== 3'b111 || o_sym[0] !== {3'd4, 3'd4, 3'd4} || o_busy[0] !== 1'b1 || o_win[0] !== 1'b0) begin
          errors++;
          $display("FAIL eval E20: stp %b sym %h busy %b win %b, expected 111 %h 1 0",
                   o_stp[0], o_sym[0], o_busy[0], o_win[0], {3'd4, 3'd4, 3'd4});
        end
      end
      if (e == 21) begin
        checks++;
        if (o_win[0] !== 1'b1 || o_cred[0] !== 4'd14 || o_busy[0] !== 1'b0) begin
          errors++;
          $display("FAIL win E21: win %b cred %0d busy %b, expected 1 14 0", o_win[0], o_cred[0], o_busy[0]);
        end
        checks++;
        if (o_win[2] !== 1'b1 || o_cred[2] !== 4'd15) begin
          errors++;
          $display("FAIL saturate: win %b cred %0d, expected 1 15", o_win[2], o_cred[2]);
        end
      end
    end
    clear = 1;
    tick();
    clear = 0;
    checks++;
    if (o_win[0] !== 1'b0 || o_lose[1] !== 1'b0 || o_busy[1] !== 1'b0 || o_stp[1] !== 3'b111) begin
      errors++;
      $display("FAIL clear_idle: win %b lose %b busy %b stp %b, expected 0 0 0 111",
               o_win[0], o_lose[1], o_busy[1], o_stp[1]);
    end
  endtask

  task automatic test_ignored();
    int cred_exp;
    int n;
    start = 1;
    tick();
    start = 0;
    cred_exp = m_cred[0];
    for (int e = 1; e <= 3; e++) begin
      start = 1;
      clear = (e != 3);
      tick();
      start = 0;
      clear = 0;
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (obs_word(i) !== exp_word(i)) begin
          errors++;
          $display("FAIL ignored_spin inst%0d edge%0d: got %h expected %h", i, e, obs_word(i), exp_word(i));
        end
      end
    end
    checks++;
    if (o_cred[0] !== CW'(cred_exp) || o_busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL ignored_spin_credit: cred %0d busy %b, expected %0d 1", o_cred[0], o_busy[0], cred_exp);
    end
    n = 0;
    while (m_mode[0] != 2 && n < 60) begin
      tick();
      n++;
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (obs_word(i) !== exp_word(i)) begin
          errors++;
          $display("FAIL ignored_run inst%0d cyc%0d: got %h expected %h", i, n, obs_word(i), exp_word(i));
        end
      end
    end
    checks++;
    if (m_mode[0] != 2) begin
      errors++;
      $display("FAIL ignored_win_timeout: model mode %0d, expected 2 within 60 cycles", m_mode[0]);
    end
    cred_exp = m_cred[0];
    start = 1;
    repeat (3) begin
      tick();
      checks++;
      if (o_win[0] !== 1'b1 || o_busy[0] !== 1'b0 || o_cred[0] !== CW'(cred_exp)) begin
        errors++;
        $display("FAIL ignored_win: win %b busy %b cred %0d, expected 1 0 %0d", o_win[0], o_busy[0], o_cred[0], cred_exp);
      end
    end
    start = 0;
    clear = 1;
    tick();
    clear = 0;
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (obs_word(i) !== exp_word(i)) begin
        errors++;
        $display("FAIL ignored_clear inst%0d: got %h expected %h", i, obs_word(i), exp_word(i));
      end
    end
  endtask

  task automatic test_reset_midspin();
    int n;
    start = 1;
    tick();
    start = 0;
    n = $urandom_range(4, 11);
    repeat (n) tick();
    checks++;
    if (o_stp[0] !== 3'b001 || o_busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL midspin_pre: stp %b busy %b, expected 001 1", o_stp[0], o_busy[0]);
    end
    reset = 1;
    start = 1;
    clear = 1;
    tick();
    reset = 0;
    start = 0;
    clear = 0;
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (o_busy[i] !== 1'b0 || o_sym[i] !== '0 || o_stp[i] !== '0 || o_cred[i] !== CW'(init_of(i))) begin
        errors++;
        $display("FAIL midspin_reset inst%0d: busy %b sym %h stp %b cred %0d, expected 0 0 0 %0d",
                 i, o_busy[i], o_sym[i], o_stp[i], o_cred[i], init_of(i));
      end
      checks++;
      if (obs_word(i) !== exp_word(i)) begin
        errors++;
        $display("FAIL midspin_model inst%0d: got %h expected %h", i, obs_word(i), exp_word(i));
      end
    end
  endtask

  task automatic test_random_games();
    for (int c = 0; c < 400; c++) begin
      start = ($urandom_range(0, 2) == 0);
      clear = ($urandom_range(0, 3) == 0);
      tick();
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (obs_word(i) !== exp_word(i)) begin
          errors++;
          $display("FAIL random inst%0d cyc%0d: got %h expected %h", i, c, obs_word(i), exp_word(i));
        end
      end
    end
    start = 0;
    clear = 0;
  endtask

  task automatic test_exhaust();
    int games;
    int n;
    reset = 1;
    tick();
    reset = 0;
    games = 0;
    while (m_cred[3] != 0 && games < 60) begin
      games++;
      start = 1;
      tick();
      start = 0;
      n = 0;
      while (any_running() && n < 100) begin
        tick();
        n++;
        for (int i = 0; i < NI; i++) begin
          checks++;
          if (obs_word(i) !== exp_word(i)) begin
            errors++;
            $display("FAIL exhaust_game%0d inst%0d: got %h expected %h", games, i, obs_word(i), exp_word(i));
          end
        end
      end
      clear = 1;
      tick();
      clear = 0;
    end
    checks++;
    if (m_cred[3] != 0) begin
      errors++;
      $display("FAIL exhaust_timeout: model credits %0d, expected 0 within 60 games", m_cred[3]);
    end
    start = 1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (o_busy[3] !== 1'b0 || o_nc[3] !== 1'b1 || o_cred[3] !== '0 || o_stp[3] !== 3'b111) begin
        errors++;
        $display("FAIL no_credit cyc%0d: busy %b nc %b cred %0d stp %b, expected 0 1 0 111",
                 c, o_busy[3], o_nc[3], o_cred[3], o_stp[3]);
      end
      checks++;
      if (obs_word(3) !== exp_word(3)) begin
        errors++;
        $display("FAIL no_credit_model cyc%0d: got %h expected %h", c, obs_word(3), exp_word(3));
      end
    end
    start = 0;
  endtask

  initial begin
    reset = 1;
    start = 0;
    clear = 0;
    for (int i = 0; i < NI; i++) begin
      m_mode[i] = 0;
      m_t[i]    = 0;
      m_cred[i] = init_of(i);
      for (int k = 0; k < NR; k++) begin
        m_base[i][k] = 0;
        m_sym[i][k]  = 0;
        m_stp[i][k]  = 0;
      end
    end
    test_reset();
    test_spec_games();
    test_ignored();
    test_reset_midspin();
    test_random_games();
    test_exhaust();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not complete within time limit");
    $fatal(1);
  end

endmodule

// File: doc/slot_game_ctrl.md
SLOT_GAME_CTRL -- requirements
Module: slot_game_ctrl

Interface
REQ-001 SHALL have parameter NUM_REELS, default 3, number of reel columns (2..8).
REQ-002 SHALL have parameter NUM_SYMBOLS, default 8, symbols per reel (2..2^SYM_W).
REQ-003 SHALL have parameter SYM_W, default 3, symbol index width.
REQ-004 SHALL have parameter SPIN_CYCLES, default 2^26, cycles in SPIN before reel 0 stops (>=1).
REQ-005 SHALL have parameter STOP_GAP, default 2^24, cycles between successive reel stops (>=1).
REQ-006 SHALL have parameters CREDIT_W (default 8), INIT_CREDITS (default 10) and PAYOUT (default 5).
REQ-007 SHALL have port: clk  input  1  sole clock, all logic on rising edge.
REQ-008 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-009 SHALL have port: start  input  1  lever; level sampled each edge.
REQ-010 SHALL have port: clear  input  1  acknowledge result, return to idle.
REQ-011 SHALL have port: reel_sym  output  NUM_REELS*SYM_W  current symbol per reel; reel i in bits [i*SYM_W +: SYM_W].
REQ-012 SHALL have port: reel_stopped  output  NUM_REELS  bit i high when reel i is stopped.
REQ-013 SHALL have ports: win, lose, busy  output  1 each; credits  output  CREDIT_W; no_credit  output  1.

Function
REQ-014 SHALL implement states IDLE, SPIN, STOPPING, EVAL, WIN, LOSE.
REQ-015 IDLE: start=1 and credits!=0 -> SPIN at that edge; credits decrement by 1 at the same edge; all reel_stopped bits clear.
REQ-016 IDLE: start=1 with credits==0 -> stay IDLE, no change.
REQ-017 SPIN: a spin counter counts 0..SPIN_CYCLES-1 (one count per edge); at the edge where it equals SPIN_CYCLES-1 -> STOPPING, and reel 0 stops.
REQ-018 STOPPING: a gap counter stops reel k+1 exactly STOP_GAP edges after reel k stops.
REQ-019 At the edge the last reel stops -> EVAL; next edge -> WIN if all reel symbols equal, else LOSE.
REQ-020 EVAL->WIN edge: credits += PAYOUT, saturating at 2^CREDIT_W-1.
REQ-021 WIN/LOSE: hold until clear=1, then -> IDLE; start is ignored in WIN/LOSE.
REQ-022 start is ignored in SPIN, STOPPING and EVAL; clear is ignored outside WIN/LOSE.
REQ-023 Each unstopped reel advances by +1 mod NUM_SYMBOLS on every edge in SPIN or STOPPING, including the edge on which it stops.
REQ-024 Reels keep their stopped symbols through IDLE; the next spin continues from those values.
REQ-025 win=1 only in WIN; lose=1 only in LOSE; busy=1 in SPIN, STOPPING and EVAL; all three are registered state decodes.
REQ-026 no_credit = (credits==0), combinational.
REQ-027 Counters SHALL be sized $clog2 of their terminal counts; no truncation at default parameters.

Reset
REQ-028 reset=1 at an edge, in any state including mid-spin: state=IDLE, all reel symbols=0, reel_stopped=all 0, credits=INIT_CREDITS, win=lose=busy=0, counters=0.
REQ-029 reset SHALL have priority over start and clear in the same cycle.

Structure
REQ-030 Package slot_pkg SHALL hold the state enum typedef and the default parameter constants.
REQ-031 A sub-module slot_reel (mod-NUM_SYMBOLS counter with advance/stop inputs, symbol and stopped outputs) SHALL be instantiated NUM_REELS times via generate.

Verification (NUM_REELS=3, NUM_SYMBOLS=8, SYM_W=3, SPIN_CYCLES=4, CREDIT_W=4, INIT_CREDITS=10, PAYOUT=5)
REQ-032 Win, STOP_GAP=8: reset, start at E0 -> reels stop at E4/E12/E20 with symbols 4,4,4; EVAL after E20; win=1 after E21; credits 10->9->14.
REQ-033 Lose, STOP_GAP=2: start at E0 -> reels stop at E4/E6/E8 with symbols 4,6,0; lose=1 after E9; credits=9; clear -> IDLE after the next edge.
REQ-034 Credit exhaustion: run 10 lose spins -> credits=0, no_credit=1; start held 5 cycles -> state stays IDLE, busy=0.
REQ-035 Saturation: CREDIT_W=4, INIT_CREDITS=14, STOP_GAP=8, one win -> credits 13+5 saturate to 15.
REQ-036 Reset mid-spin: assert reset while STOPPING with reel 0 stopped -> next edge IDLE, reel_sym=0, reel_stopped=0, credits=10.
REQ-037 Ignored inputs: start pulsed during SPIN and WIN, clear pulsed during SPIN -> no state, credit or counter change.
